// File: rtl/tran_4x4_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tran_4x4_pipe
// Description : Two-stage pipelined 4x4 forward integer transform
//               Y = M * X * M^T. M is the H.264 core matrix or the 4x4
//               Hadamard matrix, chosen per block by in_mode. Valid/ready
//               handshake on both sides, optional saturation to OUT_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module tran_4x4_pipe #(
    parameter int IN_WIDTH  = 9,
    parameter int OUT_WIDTH = 15,
    parameter int SATURATE  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic signed [IN_WIDTH-1:0]  residuals   [16],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_mode,
    output logic signed [OUT_WIDTH-1:0] transformed [16],
    output logic                        out_sat
);

    // Column-pass results need 3 extra bits, the full 2-D result needs 6.
    localparam int c_WT = IN_WIDTH + 3;
    localparam int c_WF = IN_WIDTH + 6;

    // One output row of the 1-D transform: row k of the matrix applied to
    // the four operands. Doubling terms are arithmetic left shifts.
    function automatic logic signed [c_WF-1:0] f_mix(
        input logic signed [c_WF-1:0] a0,
        input logic signed [c_WF-1:0] a1,
        input logic signed [c_WF-1:0] a2,
        input logic signed [c_WF-1:0] a3,
        input logic                   hadamard,
        input logic [1:0]             k
    );
        logic signed [c_WF-1:0] v;
        case (k)
            2'd0:    v = a0 + a1 + a2 + a3;
            2'd1:    v = hadamard ? (a0 + a1 - a2 - a3)
                                  : ((a0 <<< 1) + a1 - a2 - (a3 <<< 1));
            2'd2:    v = a0 - a1 - a2 + a3;
            default: v = hadamard ? (a0 - a1 + a2 - a3)
                                  : (a0 - (a1 <<< 1) + (a2 <<< 1) - a3);
        endcase
        return v;
    endfunction

    // Handshake / advance control
    logic w_out_adv;
    logic w_s1_adv;

    // Stage registers
    logic                        r_s1_v;
    logic                        r_s1_mode;
    logic signed [c_WT-1:0]      r_t   [16];
    logic                        r_out_v;
    logic                        r_out_mode;
    logic                        r_out_sat;
    logic signed [OUT_WIDTH-1:0] r_y   [16];

    // Combinational datapath
    logic signed [c_WT-1:0]      w_col [16];
    logic signed [c_WF-1:0]      w_row [16];
    logic signed [OUT_WIDTH-1:0] w_nar [16];
    logic [15:0]                 w_clip;
    logic                        w_any_clip;

    // An output slot frees when empty or being consumed; stage 1 may then
    // move forward. Everything freezes while enable is low.
    assign w_out_adv = enable && (!r_out_v || out_ready);
    assign w_s1_adv  = enable && (!r_s1_v || w_out_adv);
    assign in_ready  = w_s1_adv;

    // Column pass: T[k][c] = sum_r M[k][r] * X[r][c]
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                w_col[4*k+c] = c_WT'(f_mix(c_WF'(residuals[c]),
                                           c_WF'(residuals[4+c]),
                                           c_WF'(residuals[8+c]),
                                           c_WF'(residuals[12+c]),
                                           in_mode, 2'(k)));
            end
        end
    end

    // Row pass at full precision: Y[k][l] = sum_c T[k][c] * M[l][c]
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                w_row[4*k+l] = f_mix(c_WF'(r_t[4*k]),
                                     c_WF'(r_t[4*k+1]),
                                     c_WF'(r_t[4*k+2]),
                                     c_WF'(r_t[4*k+3]),
                                     r_s1_mode, 2'(l));
            end
        end
    end

    // Narrowing of each coefficient to OUT_WIDTH
    for (genvar i = 0; i < 16; i++) begin : g_lane
        if (OUT_WIDTH >= c_WF) begin : g_wide
            // Output is wide enough for every possible result.
            assign w_nar[i]  = OUT_WIDTH'(w_row[i]);
            assign w_clip[i] = 1'b0;
        end else if (SATURATE != 0) begin : g_sat
            localparam logic signed [c_WF-1:0] c_MAXF =
                c_WF'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
            localparam logic signed [c_WF-1:0] c_MINF =
                c_WF'(-(64'sd1 <<< (OUT_WIDTH - 1)));
            logic w_hi;
            logic w_lo;
            assign w_hi      = (w_row[i] > c_MAXF);
            assign w_lo      = (w_row[i] < c_MINF);
            assign w_nar[i]  = w_hi ? OUT_WIDTH'(c_MAXF) :
                               w_lo ? OUT_WIDTH'(c_MINF) :
                                      OUT_WIDTH'(w_row[i]);
            assign w_clip[i] = w_hi | w_lo;
        end else begin : g_trunc
            // Wrap-around: keep the low OUT_WIDTH bits.
            assign w_nar[i]  = OUT_WIDTH'(w_row[i]);
            assign w_clip[i] = 1'b0;
        end
    end

    assign w_any_clip = |w_clip;

    // Stage 1 register: column-pass result and mode of the accepted block
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_v    <= 1'b0;
            r_s1_mode <= 1'b0;
            r_t       <= '{default: '0};
        end else if (w_s1_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_mode <= in_mode;
                r_t       <= w_col;
            end
        end
    end

    // Output register: narrowed coefficients, mode tag and clamp flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_v    <= 1'b0;
            r_out_mode <= 1'b0;
            r_out_sat  <= 1'b0;
            r_y        <= '{default: '0};
        end else if (w_out_adv) begin
            r_out_v <= r_s1_v;
            if (r_s1_v) begin
                r_out_mode <= r_s1_mode;
                r_out_sat  <= w_any_clip;
                r_y        <= w_nar;
            end
        end
    end

    assign out_valid   = r_out_v;
    assign out_mode    = r_out_mode;
    assign out_sat     = r_out_sat;
    assign transformed = r_y;

endmodule
`default_nettype wire

// File: tb/tb_tran_4x4_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_tran_4x4_pipe
// Description : Self-checking bench for tran_4x4_pipe. Three instances share
//               one stimulus stream: default widths, 12-bit saturating and
//               12-bit truncating. A matrix-multiply reference model feeds an
//               in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tran_4x4_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                enable;
    logic                in_valid;
    logic                in_mode;
    logic                out_ready;
    logic signed [8:0]   res [16];

    logic                ir0, ir1, ir2;
    logic                ov0, ov1, ov2;
    logic                om0, om1, om2;
    logic                os0, os1, os2;
    logic signed [14:0]  tf0 [16];
    logic signed [11:0]  tf1 [16];
    logic signed [11:0]  tf2 [16];

    tran_4x4_pipe #(.IN_WIDTH(9), .OUT_WIDTH(15), .SATURATE(1)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ready(ir0), .in_mode(in_mode), .residuals(res), .out_valid(ov0),
        .out_ready(out_ready), .out_mode(om0), .transformed(tf0), .out_sat(os0));

    tran_4x4_pipe #(.IN_WIDTH(9), .OUT_WIDTH(12), .SATURATE(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ready(ir1), .in_mode(in_mode), .residuals(res), .out_valid(ov1),
        .out_ready(out_ready), .out_mode(om1), .transformed(tf1), .out_sat(os1));

    tran_4x4_pipe #(.IN_WIDTH(9), .OUT_WIDTH(12), .SATURATE(0)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_ready(ir2), .in_mode(in_mode), .residuals(res), .out_valid(ov2),
        .out_ready(out_ready), .out_mode(om2), .transformed(tf2), .out_sat(os2));

    int n_vec = 0;
    int n_err = 0;

    int c_core [16] = '{1, 1, 1, 1,  2, 1, -1, -2,  1, -1, -1, 1,  1, -2, 2, -1};
    int c_had  [16] = '{1, 1, 1, 1,  1, 1, -1, -1,  1, -1, -1, 1,  1, -1, 1, -1};
    int c_imp  [16] = '{1, 2, 1, 1,  2, 4, 2, 2,  1, 2, 1, 1,  1, 2, 1, 1};

    // Scoreboard: 16 full-precision coefficients per block plus its mode
    longint q_y [$];
    bit     q_mode [$];
    bit     last_acc;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint narrow(input longint v, input int ow, input bit sat,
                                      output bit clip);
        longint mx;
        longint mn;
        mx   = (64'sd1 <<< (ow - 1)) - 64'sd1;
        mn   = -mx - 64'sd1;
        clip = 1'b0;
        if (sat) begin
            if (v > mx) begin clip = 1'b1; return mx; end
            if (v < mn) begin clip = 1'b1; return mn; end
            return v;
        end
        return (v <<< (64 - ow)) >>> (64 - ow);
    endfunction

    // Reference: Y = M * X * M^T with plain integer matrix products
    task automatic model_push();
        int m [16];
        int t [16];
        int s;
        for (int i = 0; i < 16; i++) m[i] = in_mode ? c_had[i] : c_core[i];
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int r = 0; r < 4; r++) s += m[4*k+r] * int'(res[4*r+c]);
                t[4*k+c] = s;
            end
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < 4; l++) begin
                s = 0;
                for (int c = 0; c < 4; c++) s += t[4*k+c] * m[4*l+c];
                q_y.push_back(longint'(s));
            end
        q_mode.push_back(in_mode);
    endtask

    // Whatever is presented as valid must be the oldest outstanding block.
    task automatic check_front();
        bit     cl;
        bit     any15 = 1'b0;
        bit     any12 = 1'b0;
        longint e;
        for (int i = 0; i < 16; i++) begin
            e = narrow(q_y[i], 15, 1'b1, cl);
            any15 |= cl;
            check_val("y_w15_sat", tf0[i], e);
            e = narrow(q_y[i], 12, 1'b1, cl);
            any12 |= cl;
            check_val("y_w12_sat", tf1[i], e);
            e = narrow(q_y[i], 12, 1'b0, cl);
            check_val("y_w12_trunc", tf2[i], e);
        end
        check_val("mode_w15", om0, q_mode[0]);
        check_val("mode_w12s", om1, q_mode[0]);
        check_val("mode_w12t", om2, q_mode[0]);
        check_val("sat_w15", os0, any15);
        check_val("sat_w12s", os1, any12);
        check_val("sat_w12t", os2, 0);
        check_val("valid_w12s", ov1, 1);
        check_val("valid_w12t", ov2, 1);
    endtask

    // One clock: sample just after the falling edge, update the scoreboard at
    // the rising edge, return at the next falling edge for new stimulus.
    task automatic cycle();
        bit acc;
        bit drn;
        acc = 1'b0;
        drn = 1'b0;
        #1;
        if (!enable) begin
            check_val("in_ready_disabled", ir0, 0);
            check_val("in_ready_disabled_w12", ir1 | ir2, 0);
        end
        if (!reset) begin
            if (ov0) begin
                if (q_mode.size() == 0) check_val("spurious_valid", ov0, 0);
                else                    check_front();
            end
            acc = in_valid && ir0 && enable;
            drn = ov0 && out_ready && enable;
        end
        @(posedge clk);
        if (reset) begin
            q_y.delete();
            q_mode.delete();
        end else begin
            if (drn && q_mode.size() > 0) begin
                for (int i = 0; i < 16; i++) void'(q_y.pop_front());
                void'(q_mode.pop_front());
            end
            if (acc) model_push();
            if (q_mode.size() > 2) check_val("blocks_in_flight", q_mode.size(), 2);
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 16; i++) res[i] = 9'(v);
    endtask

    // Send one block with a free output and wait the two-cycle latency.
    task automatic run_single(input bit mode);
        in_mode   = mode;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check_val("latency_cycle1_valid", ov0, 0);
        cycle();
        check_val("latency_cycle2_valid", ov0, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int n = 0; n < 20 && q_mode.size() > 0; n++) cycle();
        check_val("drain_left_blocks", q_mode.size(), 0);
        cycle();
        check_val("drained_valid", ov0, 0);
    endtask

    task automatic rand_block();
        int pat;
        int v;
        pat = int'($urandom_range(0, 3));
        v   = ($urandom_range(0, 1) != 0) ? 255 : -256;
        for (int i = 0; i < 16; i++) begin
            case (pat)
                0:       res[i] = 9'(int'($urandom_range(0, 511)) - 256);
                1:       res[i] = 9'(v);
                2:       res[i] = 9'(($urandom_range(0, 1) != 0) ? 255 : -256);
                default: res[i] = 9'(int'($urandom_range(0, 15)) - 8);
            endcase
        end
        in_mode = $urandom_range(0, 1) != 0;
    endtask

    initial begin
        int k;
        reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
        out_ready = 1'b1; last_acc = 1'b0;
        fill(0);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check_val("rst_out_valid", ov0, 0);
        check_val("rst_out_mode", om0, 0);
        check_val("rst_out_sat", os0, 0);
        check_val("rst_in_ready", ir0, 1);
        for (int i = 0; i < 16; i++) check_val("rst_transformed", tf0[i], 0);
        @(negedge clk);

        // Flat block, both modes
        fill(1);
        run_single(1'b0);
        check_val("flat_core_dc", tf0[0], 16);
        for (int i = 1; i < 16; i++) check_val("flat_core_ac", tf0[i], 0);
        check_val("flat_core_sat", os0, 0);
        cycle();
        run_single(1'b1);
        check_val("flat_had_dc", tf0[0], 16);
        check_val("flat_had_ac", tf0[15], 0);
        check_val("flat_had_mode", om0, 1);
        cycle();

        // Impulse
        fill(0);
        res[0] = 9'sd1;
        run_single(1'b0);
        for (int i = 0; i < 16; i++) check_val("impulse_core", tf0[i], c_imp[i]);
        cycle();
        run_single(1'b1);
        for (int i = 0; i < 16; i++) check_val("impulse_had", tf0[i], 1);
        cycle();

        // Range extremes
        fill(-256);
        run_single(1'b0);
        check_val("min_dc_w15", tf0[0], -4096);
        check_val("min_ac_w15", tf0[1], 0);
        cycle();
        fill(255);
        run_single(1'b0);
        check_val("max_dc_w15", tf0[0], 4080);
        check_val("max_dc_w12_sat", tf1[0], 2047);
        check_val("max_flag_w12_sat", os1, 1);
        check_val("max_dc_w12_trunc", tf2[0], -16);
        check_val("max_flag_w12_trunc", os2, 0);
        cycle();

        // Backpressure: only two blocks fit while the output is stalled
        out_ready = 1'b0;
        k = 1;
        for (int n = 0; n < 4; n++) begin
            fill(k);
            in_mode  = 1'b0;
            in_valid = 1'b1;
            cycle();
            if (last_acc) k++;
        end
        check_val("bp_blocks_accepted", k - 1, 2);
        #1;
        check_val("bp_in_ready_full", ir0, 0);
        check_val("bp_dc_first", tf0[0], 16);
        @(negedge clk);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && k <= 4; n++) begin
            fill(k);
            cycle();
            if (last_acc) k++;
        end
        check_val("bp_all_accepted", k, 5);
        drain();

        // Enable low mid-stream: nothing moves
        out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            fill(n + 5);
            in_valid = 1'b1;
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        enable    = 1'b0;
        for (int n = 0; n < 3; n++) cycle();
        check_val("en_low_held_blocks", q_mode.size(), 2);
        check_val("en_low_valid", ov0, 1);
        check_val("en_low_dc", tf0[0], 80);
        enable = 1'b1;
        drain();

        // Reset with two blocks in flight
        out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            fill(n + 9);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check_val("rst2_out_valid", ov0, 0);
        check_val("rst2_in_ready", ir0, 1);
        for (int i = 0; i < 16; i++) check_val("rst2_transformed", tf0[i], 0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) cycle();

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            enable    = ($urandom_range(0, 99) < 85);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 70);
            rand_block();
            cycle();
        end
        reset = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
